hs32_sram_bankctl: RTL
======================

HS32_SRAM_BANKCTL -- requirements
Module: hs32_sram_bankctl

Interface
REQ-001 SHALL provide parameter NBANKS, default 4, meaning number of 32x256 SRAM macro banks; legal values are 2, 4 and 8.
REQ-002 SHALL provide parameter INTERLEAVE, default 0, meaning bank select source: 0 selects the bank from the high address bits, 1 selects it from the low address bits.
REQ-003 SHALL define BW = log2(NBANKS) and AW = 8+BW.
REQ-004 wb_clk_i  in  1  sole clock; the block has one clock and its reset is synchronous and active-high.
REQ-005 wb_rst_i  in  1  synchronous, active-high reset.
REQ-006 cpu_stb  in  1  CPU request; held high until cpu_ack.
REQ-007 cpu_we  in  1  1=write, 0=read.
REQ-008 cpu_sel  in  4  byte-lane write mask.
REQ-009 cpu_addr  in  AW  word address.
REQ-010 cpu_dtw  in  32  write data.
REQ-011 cpu_ack  out  1  single-cycle completion pulse.
REQ-012 cpu_dtr  out  32  read data, valid while cpu_ack=1.
REQ-013 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone slave controls; present only with HS32_SRAM_WB_EN.
REQ-014 wbs_sel_i  in  4 / wbs_adr_i  in  32 (word address in bits [AW+1:2]) / wbs_dat_i  in  32; present only with HS32_SRAM_WB_EN.
REQ-015 wbs_ack_o  out  1 / wbs_dat_o  out  32; present only with HS32_SRAM_WB_EN.
REQ-016 ram_csb  out  NBANKS  per-bank active-low chip select.
REQ-017 ram_web  out  1  shared active-low write enable.
REQ-018 ram_wmask  out  4  shared write mask.
REQ-019 ram_addr  out  8  shared row address.
REQ-020 ram_din  out  32  shared write data.
REQ-021 ram_dout  in  NBANKS*32  per-bank read data, bank k at bits [32k+31:32k].

Function
REQ-022 With INTERLEAVE=0 the bank SHALL be addr[AW-1:8] and the row addr[7:0]; with INTERLEAVE=1 the bank SHALL be addr[BW-1:0] and the row addr[AW-1:BW].
REQ-023 The FSM SHALL have four states: IDLE, ISSUE, RDWAIT and RESP.
REQ-024 IDLE->ISSUE when any requester is pending; the winner's command, address, mask and data SHALL be latched into registers at that edge.
REQ-025 In ISSUE exactly one ram_csb bit SHALL be low, with ram_web=~we and ram_addr/ram_din/ram_wmask driven from the latched values.
REQ-026 ISSUE->RESP for a write; ISSUE->RDWAIT for a read.
REQ-027 In RDWAIT the selected bank's ram_dout SHALL be captured into the response register; RDWAIT->RESP.
REQ-028 In RESP the winner's ack SHALL pulse for exactly one cycle with its dtr driven from the response register; RESP->IDLE.
REQ-029 Latency from strobe sampled in IDLE to ack: write 2 cycles, read 3 cycles; one transaction is outstanding at a time.
REQ-030 When not in ISSUE, all ram_csb bits SHALL be 1 and ram_web SHALL be 1.
REQ-031 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester that did not win the last grant; after reset the CPU has priority.
REQ-032 A request dropped before its ack SHALL still complete internally; its ack SHALL be suppressed if its strobe is low in RESP.
REQ-033 cpu_dtr and wbs_dat_o SHALL hold their last value outside RESP.

Reset
REQ-034 While wb_rst_i=1: state=IDLE, ram_csb=all ones, ram_web=1, cpu_ack=0, wbs_ack_o=0, cpu_dtr=0, wbs_dat_o=0, the latched registers=0 and the round-robin pointer=CPU.
REQ-035 Reset asserted mid-transaction SHALL abort it with no ack, and no ram_csb bit SHALL be low in the following cycle.

Configuration
REQ-036 Macro HS32_SRAM_WB_EN defined: the Wishbone port exists, a request is wbs_cyc_i&wbs_stb_i, and it is arbitrated per REQ-031.
REQ-037 Macro HS32_SRAM_WB_EN undefined: the wbs_* ports are absent, the arbiter is removed and the CPU is the only requester; timing is unchanged.

Verification
REQ-038 NBANKS=4, INTERLEAVE=0: CPU write addr 0x2A5, sel=1111, data 0xDEADBEEF -> ram_csb=1011, ram_addr=0xA5, ram_web=0 for one cycle, cpu_ack 2 cycles after strobe.
REQ-039 Same address read with the bank model returning 0xDEADBEEF -> cpu_ack 3 cycles after strobe, cpu_dtr=0xDEADBEEF.
REQ-040 INTERLEAVE=1, read addr 0x2A5 -> ram_csb=1101, ram_addr=0xA9.
REQ-041 Byte write sel=0100 of 0x00FF0000 over 0x11223344 -> readback 0x11FF3344.
REQ-042 With HS32_SRAM_WB_EN, CPU and WB strobing continuously -> grants alternate CPU, WB, CPU, WB with no lost acks.
REQ-043 wb_rst_i pulsed during RDWAIT -> no ack, ram_csb=all ones the next cycle, and a fresh read afterwards completes normally.

Source files
------------

// File: rtl/hs32_sram_bankctl.sv
// -----------------------------------------------------------------------------
// hs32_sram_bankctl
//   Single-port bank controller for NBANKS 32x256 SRAM macros. It accepts
//   one word transaction at a time from the CPU (and, when HS32_SRAM_WB_EN
//   is defined, from a Wishbone slave port). Round-robin arbitration runs
//   between the two requesters. Each transaction goes through the states
//   IDLE -> ISSUE -> (RDWAIT) -> RESP.
//
// Configuration macro:
//   HS32_SRAM_WB_EN   defined   : Wishbone slave port and arbiter present
//                     undefined : CPU is the only requester
//
// Parameters:
//   NBANKS     number of SRAM banks (2, 4 or 8)
//   INTERLEAVE 0: bank = high address bits, 1: bank = low address bits
//
// Ports:
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   cpu_stb/we/sel/addr/dtw   CPU request; strobe held until cpu_ack
//   cpu_ack, cpu_dtr       one-cycle completion pulse, read data
//   wbs_*                  Wishbone slave (only with HS32_SRAM_WB_EN)
//   ram_csb                per-bank active-low chip select
//   ram_web, ram_wmask     shared write enable (active-low) and byte mask
//   ram_addr, ram_din      shared row address and write data
//   ram_dout               per-bank read data, bank k at [32k+31:32k]
// -----------------------------------------------------------------------------
module hs32_sram_bankctl #(
  parameter  int NBANKS     = 4,
  parameter  int INTERLEAVE = 0,
  localparam int BW         = $clog2(NBANKS),
  localparam int AW         = 8 + BW
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cpu_stb,
  input  logic                 cpu_we,
  input  logic [3:0]           cpu_sel,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [31:0]          cpu_dtw,
  output logic                 cpu_ack,
  output logic [31:0]          cpu_dtr,
`ifdef HS32_SRAM_WB_EN
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
`endif
  output logic [NBANKS-1:0]    ram_csb,
  output logic                 ram_web,
  output logic [3:0]           ram_wmask,
  output logic [7:0]           ram_addr,
  output logic [31:0]          ram_din,
  input  logic [NBANKS*32-1:0] ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Command latched at the IDLE->ISSUE edge
  logic                r_we;
  logic [3:0]          r_sel;
  logic [AW-1:0]       r_addr;
  logic [31:0]         r_dat;
  logic                r_gnt_wb;

  // Per-requester response registers; they hold between transactions
  logic [31:0]         r_cpu_dtr;

  logic                w_req_any;
  logic                w_pick_wb;
  logic                w_in_we;
  logic [3:0]          w_in_sel;
  logic [AW-1:0]       w_in_addr;
  logic [31:0]         w_in_dat;

  logic [BW-1:0]       w_bank;
  logic [7:0]          w_row;
  logic [NBANKS-1:0]   w_onehot;
  logic [31:0]         w_bank_dout;

`ifdef HS32_SRAM_WB_EN
  logic                r_prio_wb;   // 1: WB wins a tie, 0: CPU wins a tie
  logic [31:0]         r_wbs_dat;
  logic                w_wb_req;

  assign w_wb_req  = wbs_cyc_i & wbs_stb_i;
  assign w_req_any = cpu_stb | w_wb_req;
  assign w_pick_wb = w_wb_req & (~cpu_stb | r_prio_wb);
  assign w_in_we   = w_pick_wb ? wbs_we_i             : cpu_we;
  assign w_in_sel  = w_pick_wb ? wbs_sel_i            : cpu_sel;
  assign w_in_addr = w_pick_wb ? wbs_adr_i[AW+1:2]    : cpu_addr;
  assign w_in_dat  = w_pick_wb ? wbs_dat_i            : cpu_dtw;
  assign wbs_dat_o = r_wbs_dat;
  assign wbs_ack_o = (r_state == S_RESP) & r_gnt_wb & w_wb_req;
`else
  assign w_req_any = cpu_stb;
  assign w_pick_wb = 1'b0;
  assign w_in_we   = cpu_we;
  assign w_in_sel  = cpu_sel;
  assign w_in_addr = cpu_addr;
  assign w_in_dat  = cpu_dtw;
`endif

  // Bank/row split of the latched word address
  assign w_bank = (INTERLEAVE != 0) ? r_addr[BW-1:0]  : r_addr[AW-1:8];
  assign w_row  = (INTERLEAVE != 0) ? r_addr[AW-1:BW] : r_addr[7:0];

  always_comb begin
    w_onehot         = '0;
    w_onehot[w_bank] = 1'b1;
  end

  assign w_bank_dout = ram_dout[{w_bank, 5'b00000} +: 32];

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_req_any) w_state_nxt = S_ISSUE;
      S_ISSUE:  w_state_nxt = r_we ? S_RESP : S_RDWAIT;
      S_RDWAIT: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // SRAM strobes are only active in ISSUE; the shared buses follow the latch
  always_comb begin
    ram_csb   = '1;
    ram_web   = 1'b1;
    ram_wmask = r_sel;
    ram_addr  = w_row;
    ram_din   = r_dat;
    if (r_state == S_ISSUE) begin
      ram_csb = ~w_onehot;
      ram_web = ~r_we;
    end
  end

  // A requester that dropped its strobe still completes, but sees no ack
  assign cpu_ack = (r_state == S_RESP) & ~r_gnt_wb & cpu_stb;
  assign cpu_dtr = r_cpu_dtr;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_addr    <= '0;
      r_dat     <= '0;
      r_gnt_wb  <= 1'b0;
      r_cpu_dtr <= '0;
`ifdef HS32_SRAM_WB_EN
      r_prio_wb <= 1'b0;
      r_wbs_dat <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_req_any) begin
        r_we     <= w_in_we;
        r_sel    <= w_in_sel;
        r_addr   <= w_in_addr;
        r_dat    <= w_in_dat;
        r_gnt_wb <= w_pick_wb;
`ifdef HS32_SRAM_WB_EN
        // Next tie goes to whoever did not win this one
        r_prio_wb <= ~w_pick_wb;
`endif
      end
      if (r_state == S_RDWAIT) begin
`ifdef HS32_SRAM_WB_EN
        if (r_gnt_wb) r_wbs_dat <= w_bank_dout;
        else          r_cpu_dtr <= w_bank_dout;
`else
        r_cpu_dtr <= w_bank_dout;
`endif
      end
    end
  end

endmodule
